// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID fields in, registered EX fields and load-use stall out.
// The master modport is the decode side; the slave modport is the pipeline register.
interface id_ex_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned REG_AW  = 5
);
  logic               flush;

  logic               id_regWrite;
  logic               id_memToReg;
  logic               id_memRead;
  logic               id_memWrite;
  logic               id_aluSrc;
  logic               id_regDst;
  logic [ALUOP_W-1:0] id_aluOp;
  logic               id_uses_rt;
  logic [DATA_W-1:0]  id_readData1;
  logic [DATA_W-1:0]  id_readData2;
  logic [DATA_W-1:0]  id_signExt;
  logic [DATA_W-1:0]  id_pc4;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;

  logic               ex_regWrite;
  logic               ex_memToReg;
  logic               ex_memRead;
  logic               ex_memWrite;
  logic               ex_aluSrc;
  logic               ex_regDst;
  logic [ALUOP_W-1:0] ex_aluOp;
  logic [DATA_W-1:0]  ex_readData1;
  logic [DATA_W-1:0]  ex_readData2;
  logic [DATA_W-1:0]  ex_signExt;
  logic [DATA_W-1:0]  ex_pc4;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_rd;
  logic               ex_valid;

  logic               stall;

  modport master (
    output flush,
    output id_regWrite, id_memToReg, id_memRead, id_memWrite, id_aluSrc, id_regDst,
    output id_aluOp, id_uses_rt,
    output id_readData1, id_readData2, id_signExt, id_pc4,
    output id_rs, id_rt, id_rd,
    input  ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_aluSrc, ex_regDst,
    input  ex_aluOp,
    input  ex_readData1, ex_readData2, ex_signExt, ex_pc4,
    input  ex_rs, ex_rt, ex_rd, ex_valid,
    input  stall
  );

  modport slave (
    input  flush,
    input  id_regWrite, id_memToReg, id_memRead, id_memWrite, id_aluSrc, id_regDst,
    input  id_aluOp, id_uses_rt,
    input  id_readData1, id_readData2, id_signExt, id_pc4,
    input  id_rs, id_rt, id_rd,
    output ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_aluSrc, ex_regDst,
    output ex_aluOp,
    output ex_readData1, ex_readData2, ex_signExt, ex_pc4,
    output ex_rs, ex_rt, ex_rd, ex_valid,
    output stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// Flush or load-use stall turns the next captured entry into an all-zero bubble.
module id_ex_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned REG_AW  = 5
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  sign_ext;
    logic [DATA_W-1:0]  pc4;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic               valid;
  } ex_entry_t;

  ex_entry_t ex_q;
  ex_entry_t ex_d;

  logic load_in_ex;
  logic rs_hit;
  logic rt_hit;
  logic stall_c;

  // Load in EX whose destination is a real register read by the ID instruction.
  always_comb begin
    load_in_ex = ex_q.mem_read & ex_q.valid & (ex_q.rt != '0);
    rs_hit     = (ex_q.rt == bus.id_rs);
    rt_hit     = bus.id_uses_rt & (ex_q.rt == bus.id_rt);
    stall_c    = load_in_ex & (rs_hit | rt_hit);
  end

  assign bus.stall = stall_c;

  // Next entry: bubble on flush or stall, otherwise the ID instruction.
  always_comb begin
    ex_d = '0;
    if (!bus.flush && !stall_c) begin
      ex_d.reg_write  = bus.id_regWrite;
      ex_d.mem_to_reg = bus.id_memToReg;
      ex_d.mem_read   = bus.id_memRead;
      ex_d.mem_write  = bus.id_memWrite;
      ex_d.alu_src    = bus.id_aluSrc;
      ex_d.reg_dst    = bus.id_regDst;
      ex_d.alu_op     = bus.id_aluOp;
      ex_d.read_data1 = bus.id_readData1;
      ex_d.read_data2 = bus.id_readData2;
      ex_d.sign_ext   = bus.id_signExt;
      ex_d.pc4        = bus.id_pc4;
      ex_d.rs         = bus.id_rs;
      ex_d.rt         = bus.id_rt;
      ex_d.rd         = bus.id_rd;
      ex_d.valid      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_regWrite  = ex_q.reg_write;
  assign bus.ex_memToReg  = ex_q.mem_to_reg;
  assign bus.ex_memRead   = ex_q.mem_read;
  assign bus.ex_memWrite  = ex_q.mem_write;
  assign bus.ex_aluSrc    = ex_q.alu_src;
  assign bus.ex_regDst    = ex_q.reg_dst;
  assign bus.ex_aluOp     = ex_q.alu_op;
  assign bus.ex_readData1 = ex_q.read_data1;
  assign bus.ex_readData2 = ex_q.read_data2;
  assign bus.ex_signExt   = ex_q.sign_ext;
  assign bus.ex_pc4       = ex_q.pc4;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_valid     = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts stall and the EX entry,
// independent monitors compare the DUT on negedge (stall) and just after posedge (EX).
module tb_id_ex_stage;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned REG_AW  = 5;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] se;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .REG_AW(REG_AW)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  logic stall_q[$];
  ent_t model_ex;
  ent_t mon_exp;
  ent_t mon_act;
  logic mon_stall;

  function automatic ent_t dut_ent();
    return {bus.ex_regWrite, bus.ex_memToReg, bus.ex_memRead, bus.ex_memWrite,
            bus.ex_aluSrc, bus.ex_regDst, bus.ex_aluOp, bus.ex_readData1,
            bus.ex_readData2, bus.ex_signExt, bus.ex_pc4, bus.ex_rs, bus.ex_rt,
            bus.ex_rd, bus.ex_valid};
  endfunction

  // Instruction builder; loads also set memToReg and aluSrc like a real lw.
  function automatic ent_t ins(input bit mr, input int rs, input int rt, input int rd,
                               input bit rw, input int op);
    ent_t e;
    e            = '0;
    e.mem_read   = mr;
    e.mem_to_reg = mr;
    e.alu_src    = mr;
    e.reg_write  = rw;
    e.alu_op     = 3'(op);
    e.rs         = 5'(rs);
    e.rt         = 5'(rt);
    e.rd         = 5'(rd);
    e.rd1        = $urandom;
    e.rd2        = $urandom;
    e.se         = $urandom;
    e.pc4        = $urandom;
    return e;
  endfunction

  task automatic drive(input ent_t in, input logic uses_rt, input logic fl);
    bus.flush        = fl;
    bus.id_regWrite  = in.reg_write;
    bus.id_memToReg  = in.mem_to_reg;
    bus.id_memRead   = in.mem_read;
    bus.id_memWrite  = in.mem_write;
    bus.id_aluSrc    = in.alu_src;
    bus.id_regDst    = in.reg_dst;
    bus.id_aluOp     = in.alu_op;
    bus.id_uses_rt   = uses_rt;
    bus.id_readData1 = in.rd1;
    bus.id_readData2 = in.rd2;
    bus.id_signExt   = in.se;
    bus.id_pc4       = in.pc4;
    bus.id_rs        = in.rs;
    bus.id_rt        = in.rt;
    bus.id_rd        = in.rd;
  endtask

  // Present one ID instruction for a cycle and record what the stage must do with it.
  task automatic step(input ent_t in, input logic uses_rt, input logic fl);
    logic hz;
    ent_t nxt;
    drive(in, uses_rt, fl);
    hz = 1'b0;
    if (model_ex.valid && model_ex.mem_read && model_ex.rt != 5'd0) begin
      if (model_ex.rt == in.rs) hz = 1'b1;
      if (uses_rt && model_ex.rt == in.rt) hz = 1'b1;
    end
    stall_q.push_back(hz);
    if (fl || hz) begin
      nxt = '0;
    end else begin
      nxt       = in;
      nxt.valid = 1'b1;
    end
    exp_q.push_back(nxt);
    model_ex = nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (dut_ent() !== ent_t'(0) || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL %s: ex=%h stall=%b, required all zero", name, dut_ent(), bus.stall);
    end
  endtask

  initial begin : stall_monitor
    forever begin
      @(negedge clk);
      if (stall_q.size() > 0) begin
        mon_stall = stall_q.pop_front();
        checks++;
        if (bus.stall !== mon_stall) begin
          errors++;
          $display("FAIL stall @%0t: got %b want %b", $time, bus.stall, mon_stall);
        end
      end
    end
  end

  initial begin : ex_monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = dut_ent();
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL ex_entry @%0t: got %h want %h", $time, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    ent_t a;
    ent_t b;
    rst      = 1'b1;
    model_ex = '0;
    drive('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check_reset("reset_init");
    rst = 1'b0;

    // Normal pass.
    a = ins(0, 3, 4, 5, 1, 3'b010);
    a.rd1 = 32'h11;
    step(a, 1'b1, 1'b0);

    // Load-use on rs: stall, bubble, then dependent instruction loads.
    step(ins(1, 1, 2, 0, 1, 0), 1'b0, 1'b0);
    b = ins(0, 2, 6, 8, 1, 2);
    step(b, 1'b1, 1'b0);
    step(b, 1'b1, 1'b0);

    // rt dependency gated by uses_rt.
    step(ins(1, 1, 7, 0, 1, 0), 1'b0, 1'b0);
    step(ins(0, 1, 7, 0, 1, 0), 1'b0, 1'b0);
    step(ins(1, 1, 7, 0, 1, 0), 1'b0, 1'b0);
    b = ins(0, 1, 7, 9, 1, 2);
    step(b, 1'b1, 1'b0);
    step(b, 1'b1, 1'b0);

    // $0 destination never stalls.
    step(ins(1, 1, 0, 0, 1, 0), 1'b0, 1'b0);
    step(ins(0, 0, 0, 3, 1, 2), 1'b1, 1'b0);

    // Flush wins over a simultaneous stall.
    step(ins(1, 1, 2, 0, 1, 0), 1'b0, 1'b0);
    step(ins(0, 2, 2, 4, 1, 2), 1'b1, 1'b1);

    // Back-to-back loads.
    step(ins(1, 1, 2, 0, 1, 0), 1'b0, 1'b0);
    b = ins(1, 2, 3, 0, 1, 0);
    step(b, 1'b0, 1'b0);
    step(b, 1'b0, 1'b0);

    // Mid-cycle asynchronous reset with a live entry in EX.
    step(ins(0, 3, 4, 5, 1, 3'b010), 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_reset("reset_async");
    @(posedge clk);
    #2;
    check_reset("reset_hold");
    rst      = 1'b0;
    model_ex = '0;

    // Randomized traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      a           = ins(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      a.mem_write = 1'($urandom_range(0, 1));
      a.reg_dst   = 1'($urandom_range(0, 1));
      step(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0 || stall_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d ex and %0d stall expectations left, required 0",
               exp_q.size(), stall_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
